kernel_b_out_pack: RTL and testbench

- Downstream stage of the kernel_B top. Consumes its STREAMW-bit output stream (kb_vout_s0 with ovalid/oready) and packs PACK consecutive items into one wide word for the memory write-back path.
- Counts items over a fixed-length stream, flags the final word, and raises a sticky done.
- Sustains 1 item/cycle with no bubbles while downstream is ready.

---
 rtl/kernel_b_out_pack_pkg.sv | 24 ++
 rtl/kernel_b_out_pack_lane_acc.sv | 65 ++++++
 rtl/kernel_b_out_pack.sv | 125 ++++++++++++
 tb/tb_kernel_b_out_pack.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_b_out_pack_pkg.sv
// Shared helpers for the kernel_B output packing path.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package kernel_b_out_pack_pkg;

    // Upper bound on lanes per word that keep_mask can describe.
    localparam int MAX_PACK = 64;

    // Bits needed to index PACK lanes. At least 1 so the lane register always exists.
    function automatic int lane_idx_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

    // Mask with the n low bits set. Callers size-cast the result down to their lane count.
    function automatic logic [MAX_PACK-1:0] keep_mask(input int n);
        logic [MAX_PACK-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_PACK; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/kernel_b_out_pack_lane_acc.sv
// Lane accumulator: tracks the lane index, buffers lanes 0..PACK-2 and assembles the word.
// Latency: word_dat/word_keep/completing are combinational from the current lane and idata.
// Backpressure: none internally; the parent only pulses acc_en on accepted items.
module kernel_b_out_pack_lane_acc
    import kernel_b_out_pack_pkg::*;
#(
    parameter int STREAMW = 32,
    parameter int PACK    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clr,
    input  logic                             acc_en,
    input  logic                             final_item,
    input  logic [STREAMW-1:0]               idata,
    output logic                             completing,
    output logic [PACK-1:0][STREAMW-1:0]     word_dat,
    output logic [PACK-1:0]                  word_keep
);

    localparam int LW = lane_idx_w(PACK);
    localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);

    logic [LW-1:0]                lane_q, lane_d;
    logic [PACK-1:0][STREAMW-1:0] acc_q, acc_d;

    // The next accepted item closes a word when it fills the top lane or is the run's last item.
    assign completing = (lane_q == LAST_LANE) || final_item;

    // Next lane index and buffered lanes; clr wins over a same-cycle accept.
    always_comb begin
        lane_d = lane_q;
        acc_d  = acc_q;
        if (clr) begin
            lane_d = '0;
            acc_d  = '0;
        end else if (acc_en) begin
            acc_d[lane_q] = idata;
            lane_d        = completing ? '0 : lane_q + 1'b1;
        end
    end

    // Word as it would be emitted if the current item completes it: stale lanes above are masked to zero.
    always_comb begin
        word_keep = PACK'(keep_mask(int'(lane_q) + 1));
        word_dat  = '0;
        for (int l = 0; l < PACK; l++) begin
            if (word_keep[l]) begin
                word_dat[l] = (LW'(l) == lane_q) ? idata : acc_q[l];
            end
        end
    end

    // Lane index and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/kernel_b_out_pack.sv
// Packs PACK consecutive kernel_B stream items into one wide word; flags the final word, sticky done.
// Latency: word registered on the edge that accepts its completing item (ovalid in the next cycle).
// Backpressure: non-completing lanes always accepted; a completing item waits until the output register is free or draining.
module kernel_b_out_pack
    import kernel_b_out_pack_pkg::*;
#(
    parameter int STREAMW = 32,
    parameter int PACK    = 4,
    parameter int NITEMS  = 1024,
    parameter int CNTW    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      ivalid,
    output logic                      iready,
    input  logic [STREAMW-1:0]        idata,
    output logic                      ovalid,
    input  logic                      oready,
    output logic [STREAMW*PACK-1:0]   odata,
    output logic [PACK-1:0]           okeep,
    output logic                      olast,
    output logic                      done,
    output logic [CNTW-1:0]           icount
);

    localparam logic [CNTW-1:0] NITEMS_C = CNTW'(NITEMS);
    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NITEMS - 1);

    logic                         ovalid_q, ovalid_d;
    logic [PACK-1:0][STREAMW-1:0] odata_q, odata_d;
    logic [PACK-1:0]              okeep_q, okeep_d;
    logic                         olast_q, olast_d;
    logic                         done_q, done_d;
    logic [CNTW-1:0]              icount_q, icount_d;

    logic                         completing;
    logic [PACK-1:0][STREAMW-1:0] word_dat;
    logic [PACK-1:0]              word_keep;
    logic                         final_item;
    logic                         last_pending;
    logic                         acc_en;
    logic                         load;
    logic                         drain;

    assign final_item   = (icount_q == LAST_IDX);
    assign last_pending = ovalid_q && olast_q;
    // A completing item may enter while the output register drains on the same edge.
    assign iready       = !rst && !done_q && !last_pending && (!completing || !ovalid_q || oready);
    assign acc_en       = ivalid && iready;
    assign load         = acc_en && completing;
    assign drain        = ovalid_q && oready;

    kernel_b_out_pack_lane_acc #(
        .STREAMW (STREAMW),
        .PACK    (PACK)
    ) u_lane_acc (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .acc_en     (acc_en),
        .final_item (final_item),
        .idata      (idata),
        .completing (completing),
        .word_dat   (word_dat),
        .word_keep  (word_keep)
    );

    // Output register, item counter and done; clr discards everything including a pending word.
    always_comb begin
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        okeep_d  = okeep_q;
        olast_d  = olast_q;
        done_d   = done_q;
        icount_d = icount_q;
        if (clr) begin
            ovalid_d = 1'b0;
            odata_d  = '0;
            okeep_d  = '0;
            olast_d  = 1'b0;
            done_d   = 1'b0;
            icount_d = '0;
        end else begin
            if (load) begin
                ovalid_d = 1'b1;
                odata_d  = word_dat;
                okeep_d  = word_keep;
                olast_d  = final_item;
            end else if (drain) begin
                ovalid_d = 1'b0;
                olast_d  = 1'b0;
            end
            if (drain && olast_q) done_d = 1'b1;
            if (acc_en && (icount_q != NITEMS_C)) icount_d = icount_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            okeep_q  <= '0;
            olast_q  <= 1'b0;
            done_q   <= 1'b0;
            icount_q <= '0;
        end else begin
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            okeep_q  <= okeep_d;
            olast_q  <= olast_d;
            done_q   <= done_d;
            icount_q <= icount_d;
        end
    end

    assign ovalid = ovalid_q;
    assign odata  = odata_q;
    assign okeep  = okeep_q;
    assign olast  = olast_q;
    assign done   = done_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_kernel_b_out_pack.sv
// Directed bench for kernel_b_out_pack: three instances (NITEMS 8, 6, 1) share the input stream.
// Latency: words observed at the negedge before the handshake edge.
// Backpressure: oready driven per cycle from each scenario.
module tb_kernel_b_out_pack;

    localparam int SW = 32;
    localparam int PK = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic [SW*PK-1:0] d;
        logic [PK-1:0]    k;
        logic             l;
    } word_t;

    localparam logic [127:0] W1  = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] W2  = {32'd8, 32'd7, 32'd6, 32'd5};
    localparam logic [127:0] W6  = {32'd0, 32'd0, 32'd6, 32'd5};
    localparam logic [127:0] WU1 = {32'd0, 32'd0, 32'd0, 32'd1};

    logic clk = 1'b0;
    logic rst, clr, ivalid, oready;
    logic [SW-1:0] idata;

    logic iready_8, ovalid_8, olast_8, done_8;
    logic iready_6, ovalid_6, olast_6, done_6;
    logic iready_1, ovalid_1, olast_1, done_1;
    logic [SW*PK-1:0] odata_8, odata_6, odata_1;
    logic [PK-1:0] okeep_8, okeep_6, okeep_1;
    logic [CW-1:0] icount_8, icount_6, icount_1;

    word_t q8[$];
    word_t q6[$];
    word_t q1[$];
    logic acc_s = 1'b0;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    kernel_b_out_pack #(.STREAMW(SW), .PACK(PK), .NITEMS(8), .CNTW(CW)) u8 (
        .clk(clk), .rst(rst), .clr(clr), .ivalid(ivalid), .iready(iready_8), .idata(idata),
        .ovalid(ovalid_8), .oready(oready), .odata(odata_8), .okeep(okeep_8), .olast(olast_8),
        .done(done_8), .icount(icount_8));

    kernel_b_out_pack #(.STREAMW(SW), .PACK(PK), .NITEMS(6), .CNTW(CW)) u6 (
        .clk(clk), .rst(rst), .clr(clr), .ivalid(ivalid), .iready(iready_6), .idata(idata),
        .ovalid(ovalid_6), .oready(oready), .odata(odata_6), .okeep(okeep_6), .olast(olast_6),
        .done(done_6), .icount(icount_6));

    kernel_b_out_pack #(.STREAMW(SW), .PACK(PK), .NITEMS(1), .CNTW(CW)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .ivalid(ivalid), .iready(iready_1), .idata(idata),
        .ovalid(ovalid_1), .oready(oready), .odata(odata_1), .okeep(okeep_1), .olast(olast_1),
        .done(done_1), .icount(icount_1));

    function automatic word_t mk(input logic [127:0] dv, input logic [3:0] kv, input logic lv);
        word_t w;
        w.d = dv;
        w.k = kv;
        w.l = lv;
        return w;
    endfunction

    // Record handshakes about to happen on the next posedge.
    always @(negedge clk) begin
        acc_s = ivalid && iready_8;
        if (!rst && !clr && oready) begin
            if (ovalid_8) q8.push_back(mk(odata_8, okeep_8, olast_8));
            if (ovalid_6) q6.push_back(mk(odata_6, okeep_6, olast_6));
            if (ovalid_1) q1.push_back(mk(odata_1, okeep_1, olast_1));
        end
    end

    // Advance one cycle; the stream moves to the next item when u8 took the current one.
    task automatic tick();
        @(posedge clk);
        #1;
        if (acc_s) idata = idata + 1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; clr = 1'b0; ivalid = 1'b0; oready = 1'b0; idata = 32'd1;
        @(posedge clk);
        #1;
        q8.delete(); q6.delete(); q1.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; ivalid = 1'b1; oready = 1'b1; idata = 32'hDEAD_BEEF;
        #3;
        nvec++;
        if ({ovalid_8, olast_8, done_8, iready_8, iready_6, iready_1} !== 6'b0) begin
            nerr++;
            $display("FAIL reset_ctrl: ovalid/olast/done/iready8/6/1 = %b, want 000000",
                     {ovalid_8, olast_8, done_8, iready_8, iready_6, iready_1});
        end
        nvec++;
        if (odata_8 !== '0 || okeep_8 !== '0 || icount_8 !== '0) begin
            nerr++;
            $display("FAIL reset_data: odata=%h okeep=%b icount=%0d, want all 0", odata_8, okeep_8, icount_8);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; ivalid = 1'b0; idata = 32'd1;
        @(negedge clk);
        #1;
        nvec++;
        if (iready_8 !== 1'b1 || icount_8 !== '0) begin
            nerr++;
            $display("FAIL reset_release: iready=%b icount=%0d, want 1 and 0", iready_8, icount_8);
        end
    endtask

    task automatic test_continuous();
        int bubbles;
        reset_dut();
        ivalid = 1'b1; oready = 1'b1; bubbles = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            #1;
            if (c <= 8 && !iready_8) bubbles++;
            if (c == 5) begin
                nvec++;
                if (ovalid_8 !== 1'b1 || odata_8 !== W1 || okeep_8 !== 4'hF || olast_8 !== 1'b0) begin
                    nerr++;
                    $display("FAIL cont_w1_timing: ovalid=%b odata=%h okeep=%b olast=%b, want 1 %h 1111 0",
                             ovalid_8, odata_8, okeep_8, olast_8, W1);
                end
            end
            if (c == 9) begin
                nvec++;
                if (ovalid_8 !== 1'b1 || olast_8 !== 1'b1 || done_8 !== 1'b0) begin
                    nerr++;
                    $display("FAIL cont_last_word: ovalid=%b olast=%b done=%b, want 1 1 0", ovalid_8, olast_8, done_8);
                end
            end
            if (c == 10) begin
                nvec++;
                if (done_8 !== 1'b1 || ovalid_8 !== 1'b0) begin
                    nerr++;
                    $display("FAIL cont_done: done=%b ovalid=%b, want 1 0", done_8, ovalid_8);
                end
            end
            tick();
        end
        nvec++;
        if (bubbles != 0) begin
            nerr++;
            $display("FAIL cont_bubbles: %0d input bubbles, want 0", bubbles);
        end
        nvec++;
        if (icount_8 !== 16'd8 || icount_6 !== 16'd6 || icount_1 !== 16'd1) begin
            nerr++;
            $display("FAIL cont_icount: %0d/%0d/%0d, want 8/6/1", icount_8, icount_6, icount_1);
        end
        nvec++;
        if ({done_8, done_6, done_1} !== 3'b111 || {iready_8, iready_6, iready_1} !== 3'b000) begin
            nerr++;
            $display("FAIL cont_final_state: done=%b iready=%b, want 111 000",
                     {done_8, done_6, done_1}, {iready_8, iready_6, iready_1});
        end
        nvec++;
        if (q8.size() != 2 || q8[0] !== mk(W1, 4'hF, 1'b0) || q8[1] !== mk(W2, 4'hF, 1'b1)) begin
            nerr++;
            $display("FAIL cont_words8: %0d words first=%h second=%h, want 2 words %h %h", q8.size(),
                     (q8.size() > 0) ? q8[0] : '0, (q8.size() > 1) ? q8[1] : '0,
                     mk(W1, 4'hF, 1'b0), mk(W2, 4'hF, 1'b1));
        end
        nvec++;
        if (q6.size() != 2 || q6[0] !== mk(W1, 4'hF, 1'b0) || q6[1] !== mk(W6, 4'b0011, 1'b1)) begin
            nerr++;
            $display("FAIL partial_words6: %0d words first=%h second=%h, want 2 words %h %h", q6.size(),
                     (q6.size() > 0) ? q6[0] : '0, (q6.size() > 1) ? q6[1] : '0,
                     mk(W1, 4'hF, 1'b0), mk(W6, 4'b0011, 1'b1));
        end
        nvec++;
        if (q1.size() != 1 || q1[0] !== mk(WU1, 4'b0001, 1'b1)) begin
            nerr++;
            $display("FAIL single_word1: %0d words first=%h, want 1 word %h", q1.size(),
                     (q1.size() > 0) ? q1[0] : '0, mk(WU1, 4'b0001, 1'b1));
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        ivalid = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            oready = !(c >= 5 && c <= 9);
            @(negedge clk);
            #1;
            if (c >= 5 && c <= 9) begin
                nvec++;
                if (ovalid_8 !== 1'b1 || odata_8 !== W1) begin
                    nerr++;
                    $display("FAIL bp_hold c%0d: ovalid=%b odata=%h, want 1 %h", c, ovalid_8, odata_8, W1);
                end
            end
            if (c == 7) begin
                nvec++;
                if (iready_8 !== 1'b1) begin
                    nerr++;
                    $display("FAIL bp_lane2_accept: iready=%b, want 1", iready_8);
                end
            end
            if (c == 8 || c == 9) begin
                nvec++;
                if (iready_8 !== 1'b0 || icount_8 !== 16'd7) begin
                    nerr++;
                    $display("FAIL bp_stall c%0d: iready=%b icount=%0d, want 0 7", c, iready_8, icount_8);
                end
            end
            if (c == 11) begin
                nvec++;
                if (ovalid_8 !== 1'b1 || odata_8 !== W2 || olast_8 !== 1'b1) begin
                    nerr++;
                    $display("FAIL bp_resume: ovalid=%b odata=%h olast=%b, want 1 %h 1", ovalid_8, odata_8, olast_8, W2);
                end
            end
            tick();
        end
        nvec++;
        if (q8.size() != 2 || q8[0] !== mk(W1, 4'hF, 1'b0) || q8[1] !== mk(W2, 4'hF, 1'b1) || done_8 !== 1'b1) begin
            nerr++;
            $display("FAIL bp_words: %0d words done=%b, want 2 words (W1, W2 last) and done=1", q8.size(), done_8);
        end
    endtask

    task automatic test_drain_load();
        reset_dut();
        ivalid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            oready = (c < 5) || (c >= 8);
            @(negedge clk);
            #1;
            if (c == 8) begin
                nvec++;
                if (iready_8 !== 1'b1 || ovalid_8 !== 1'b1 || odata_8 !== W1) begin
                    nerr++;
                    $display("FAIL dl_coincide: iready=%b ovalid=%b odata=%h, want 1 1 %h", iready_8, ovalid_8, odata_8, W1);
                end
            end
            if (c == 9) begin
                nvec++;
                if (ovalid_8 !== 1'b1 || odata_8 !== W2 || okeep_8 !== 4'hF || olast_8 !== 1'b1) begin
                    nerr++;
                    $display("FAIL dl_next_word: ovalid=%b odata=%h okeep=%b olast=%b, want 1 %h 1111 1",
                             ovalid_8, odata_8, okeep_8, olast_8, W2);
                end
            end
            tick();
        end
        nvec++;
        if (q8.size() != 2 || done_8 !== 1'b1) begin
            nerr++;
            $display("FAIL dl_words: %0d words done=%b, want 2 and 1", q8.size(), done_8);
        end
    endtask

    // Fill one word plus two lanes while stalled, then drop state via rst or clr and rerun cleanly.
    task automatic test_abort(input bit use_clr);
        reset_dut();
        ivalid = 1'b1; oready = 1'b0;
        for (int c = 1; c <= 6; c++) tick();
        nvec++;
        if (ovalid_8 !== 1'b1 || icount_8 !== 16'd6) begin
            nerr++;
            $display("FAIL abort_pre clr=%0d: ovalid=%b icount=%0d, want 1 6", use_clr, ovalid_8, icount_8);
        end
        if (use_clr) begin
            clr = 1'b1;
            ivalid = 1'b0;
            tick();
            clr = 1'b0;
            #1;
        end else begin
            #2;
            rst = 1'b1;
            #1;
        end
        nvec++;
        if (ovalid_8 !== 1'b0 || odata_8 !== '0 || okeep_8 !== '0 || icount_8 !== '0 || done_8 !== 1'b0) begin
            nerr++;
            $display("FAIL abort_cleared clr=%0d: ovalid=%b odata=%h okeep=%b icount=%0d done=%b, want all 0",
                     use_clr, ovalid_8, odata_8, okeep_8, icount_8, done_8);
        end
        if (!use_clr) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        q8.delete();
        idata = 32'd1; ivalid = 1'b1; oready = 1'b1;
        for (int c = 1; c <= 12; c++) tick();
        nvec++;
        if (q8.size() != 2 || q8[0] !== mk(W1, 4'hF, 1'b0) || q8[1] !== mk(W2, 4'hF, 1'b1)) begin
            nerr++;
            $display("FAIL abort_rerun clr=%0d: %0d words first=%h, want 2 words starting %h", use_clr, q8.size(),
                     (q8.size() > 0) ? q8[0] : '0, mk(W1, 4'hF, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_backpressure();
        test_drain_load();
        test_abort(1'b0);
        test_abort(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
